// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: register-file geometry and writeback requester indices.
package rv32i_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int SRC_ALU    = 0;
  localparam int SRC_LSU    = 1;
  localparam int SRC_CSR    = 2;
  localparam int NUM_WB_SRC = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
// Produces a one-hot grant, the encoded winner index and an any-request flag.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[IW'(w_j)]) begin
        o_any             = 1'b1;
        o_idx             = IW'(w_j);
        o_gnt[IW'(w_j)]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin sharing of the regfile write port with a one-cycle registered output stage.
// Optional decode bypass of the in-flight write is compiled in with RF_WR_BYPASS_EN.
module regfile_wr_arbiter
  import rv32i_pkg::*;
#(
  parameter  int NumReq    = 3,
  parameter  int DataWidth = XLEN,
  parameter  int AddrWidth = REG_ADDR_W,
  localparam int SrcW      = $clog2(NumReq)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NumReq-1:0]           Req_Valid,
  output logic [NumReq-1:0]           Req_Ready,
  input  logic [NumReq*AddrWidth-1:0] Req_Addr,
  input  logic [NumReq*DataWidth-1:0] Req_Data,
  input  logic                        Port_Hold,
  output logic                        Wr_En,
  output logic [AddrWidth-1:0]        Wr_Addr,
  output logic [DataWidth-1:0]        Wr_Data,
  output logic [SrcW-1:0]             Wr_Src,
  input  logic [AddrWidth-1:0]        Byp_Addr,
  output logic                        Byp_Hit,
  output logic [DataWidth-1:0]        Byp_Data
);
  logic [SrcW-1:0]      r_ptr;
  logic                 r_wr_en;
  logic [AddrWidth-1:0] r_wr_addr;
  logic [DataWidth-1:0] r_wr_data;
  logic [SrcW-1:0]      r_wr_src;

  logic [NumReq-1:0]    w_gnt;
  logic [SrcW-1:0]      w_idx;
  logic                 w_any;
  logic                 w_xfer;
  logic [AddrWidth-1:0] w_sel_addr;
  logic [DataWidth-1:0] w_sel_data;
  logic [SrcW-1:0]      w_ptr_nxt;

  rr_arbiter #(.N(NumReq)) u_rr (
    .i_req (Req_Valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Hold and reset gate the grant itself so no transfer can be seen by a requester.
  assign Req_Ready  = (Reset || Port_Hold) ? '0 : w_gnt;
  assign w_xfer     = w_any && !Port_Hold && !Reset;
  assign w_sel_addr = Req_Addr[int'(w_idx)*AddrWidth +: AddrWidth];
  assign w_sel_data = Req_Data[int'(w_idx)*DataWidth +: DataWidth];
  assign w_ptr_nxt  = (int'(w_idx) == NumReq - 1) ? '0 : w_idx + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_src  <= '0;
    end else begin
      // x0 transfers still complete and update the data path, only the enable is suppressed.
      r_wr_en <= w_xfer && (w_sel_addr != AddrWidth'(REG_ZERO));
      if (w_xfer) begin
        r_ptr     <= w_ptr_nxt;
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
        r_wr_src  <= w_idx;
      end
    end
  end

  assign Wr_En   = r_wr_en;
  assign Wr_Addr = r_wr_addr;
  assign Wr_Data = r_wr_data;
  assign Wr_Src  = r_wr_src;

`ifdef RF_WR_BYPASS_EN
  assign Byp_Hit  = r_wr_en && (r_wr_addr == Byp_Addr) && (Byp_Addr != AddrWidth'(REG_ZERO));
  assign Byp_Data = Byp_Hit ? r_wr_data : '0;
`else
  logic w_unused_byp;
  assign w_unused_byp = ^Byp_Addr;
  assign Byp_Hit      = 1'b0;
  assign Byp_Data     = '0;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic against a queue-free
// distance-based round-robin model of the arbiter and its registered write port.
module tb_regfile_wr_arbiter;
  import rv32i_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [N-1:0]      rv;
  logic [AW-1:0]     ra [N];
  logic [DW-1:0]     rd [N];
  logic [N*AW-1:0]   addr_bus;
  logic [N*DW-1:0]   data_bus;
  logic              hold;
  logic [AW-1:0]     byp_addr;
  logic [N-1:0]      rdy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        wr_src;
  logic              byp_hit;
  logic [DW-1:0]     byp_data;

  int errors = 0;
  int checks = 0;

  int            m_ptr;
  int            m_win;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_src;

  always #5 Clk = ~Clk;

  always_comb begin
    addr_bus = '0;
    data_bus = '0;
    for (int i = 0; i < N; i++) begin
      addr_bus[i*AW +: AW] = ra[i];
      data_bus[i*DW +: DW] = rd[i];
    end
  end

  regfile_wr_arbiter #(.NumReq(N), .DataWidth(DW), .AddrWidth(AW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req_Valid (rv),
    .Req_Ready (rdy),
    .Req_Addr  (addr_bus),
    .Req_Data  (data_bus),
    .Port_Hold (hold),
    .Wr_En     (wr_en),
    .Wr_Addr   (wr_addr),
    .Wr_Data   (wr_data),
    .Wr_Src    (wr_src),
    .Byp_Addr  (byp_addr),
    .Byp_Hit   (byp_hit),
    .Byp_Data  (byp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_src  = 0;
  endtask

  // Winner = valid requester at the smallest forward distance from the pointer.
  function automatic int model_winner();
    int best, bestd, d;
    best  = -1;
    bestd = N;
    if (hold) return -1;
    for (int j = 0; j < N; j++) begin
      d = (j - m_ptr + N) % N;
      if (rv[j] && d < bestd) begin
        best  = j;
        bestd = d;
      end
    end
    return best;
  endfunction

  // Called at a negedge with inputs set; checks every output, then advances one clock.
  task automatic step();
    logic [N-1:0]  e_rdy;
    logic          e_hit;
    logic [DW-1:0] e_bd;
    #1;
    m_win = model_winner();
    e_rdy = (m_win >= 0) ? N'(1 << m_win) : '0;
`ifdef RF_WR_BYPASS_EN
    e_hit = m_en && (m_addr == byp_addr) && (byp_addr != '0);
`else
    e_hit = 1'b0;
`endif
    e_bd = e_hit ? m_data : '0;
    chk("req_ready", 64'(rdy), 64'(e_rdy));
    chk("wr_en",     64'(wr_en), 64'(m_en));
    chk("wr_addr",   64'(wr_addr), 64'(m_addr));
    chk("wr_data",   64'(wr_data), 64'(m_data));
    chk("wr_src",    64'(wr_src), 64'(m_src));
    chk("byp_hit",   64'(byp_hit), 64'(e_hit));
    chk("byp_data",  64'(byp_data), 64'(e_bd));
    @(posedge Clk);
    @(negedge Clk);
    if (m_win >= 0) begin
      m_en   = (ra[m_win] != '0);
      m_addr = ra[m_win];
      m_data = rd[m_win];
      m_src  = m_win;
      m_ptr  = (m_win + 1) % N;
      rv[m_win] = 1'b0;
    end else begin
      m_en = 1'b0;
    end
  endtask

  task automatic mid_cycle_reset(input string tag);
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_ready"}, 64'(rdy), 64'd0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    rv       = '0;
    hold     = 1'b0;
    byp_addr = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = AW'(i + 1);
      rd[i] = DW'(32'hA0 + i);
    end
    model_reset();
    rv = 3'b111;
    @(negedge Clk);
    @(negedge Clk);
    #1;
    chk("rst_wr_en",   64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_wr_src",  64'(wr_src), 64'd0);
    chk("rst_ready",   64'(rdy), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // T1: reset in the middle of a full burst
    for (int c = 0; c < 2; c++) begin
      rv = 3'b111;
      step();
    end
    rv = 3'b111;
    mid_cycle_reset("t1");
    rv = 3'b111;
    #1;
    chk("t1_first_grant", 64'(rdy), 64'b001);

    // T2: continuous round robin
    for (int c = 0; c < 6; c++) begin
      rv = 3'b111;
      #1;
      chk("t2_grant", 64'(rdy), 64'(1 << (c % 3)));
      step();
      chk("t2_wr_en",  64'(wr_en), 64'd1);
      chk("t2_wr_src", 64'(wr_src), 64'(c % 3));
    end

    // T3: x0 write is consumed but not issued
    rv    = 3'b010;
    ra[1] = '0;
    rd[1] = 32'hDEADBEEF;
    #1;
    chk("t3_grant", 64'(rdy), 64'b010);
    step();
    chk("t3_wr_en",   64'(wr_en), 64'd0);
    chk("t3_wr_data", 64'(wr_data), 64'hDEADBEEF);
    chk("t3_wr_src",  64'(wr_src), 64'd1);
    chk("t3_model_ptr", 64'(m_ptr), 64'd2);
    ra[1] = 5'd2;
    rv    = 3'b111;
    #1;
    chk("t3_ptr_at_2", 64'(rdy), 64'b100);
    step();

    // T4: port hold
    rv    = 3'b100;
    ra[2] = 5'd9;
    rd[2] = 32'h44;
    hold  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_held", 64'(rdy), 64'd0);
      step();
    end
    hold = 1'b0;
    #1;
    chk("t4_release", 64'(rdy), 64'b100);
    step();
    chk("t4_wr_en",   64'(wr_en), 64'd1);
    chk("t4_wr_addr", 64'(wr_addr), 64'd9);
    chk("t4_wr_data", 64'(wr_data), 64'h44);

    // T5: same-address collision
    rv    = 3'b101;
    ra[0] = 5'd5;
    rd[0] = 32'h11;
    ra[2] = 5'd5;
    rd[2] = 32'h22;
    #1;
    chk("t5_grant", 64'(rdy), 64'b001);
    step();
    chk("t5_first_addr", 64'(wr_addr), 64'd5);
    chk("t5_first_data", 64'(wr_data), 64'h11);
    step();
    chk("t5_second_en",   64'(wr_en), 64'd1);
    chk("t5_second_data", 64'(wr_data), 64'h22);

    // T6: bypass lookup of the in-flight write
    rv    = 3'b001;
    ra[0] = 5'd7;
    rd[0] = 32'hCAFE;
    step();
    byp_addr = 5'd7;
    #1;
`ifdef RF_WR_BYPASS_EN
    chk("t6_hit",  64'(byp_hit), 64'd1);
    chk("t6_data", 64'(byp_data), 64'hCAFE);
`else
    chk("t6_hit",  64'(byp_hit), 64'd0);
    chk("t6_data", 64'(byp_data), 64'd0);
`endif
    byp_addr = 5'd0;
    #1;
    chk("t6_x0_hit", 64'(byp_hit), 64'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && ($urandom % 3) == 0) begin
          rv[i] = 1'b1;
          ra[i] = (($urandom % 4) == 0) ? '0 : AW'($urandom);
          rd[i] = DW'($urandom);
        end
      end
      hold     = (($urandom % 5) == 0);
      byp_addr = (($urandom % 2) == 0) ? m_addr : AW'($urandom);
      step();
      if (c == 1500) begin
        mid_cycle_reset("rand_rst");
        rv = '0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
